rr_arbiter4: RTL and testbench

//   Round-robin arbiter sharing one 4-input resource (a mux4-selected bus or memory port)

---
 rtl/rr_arbiter4.sv | 128 ++++++++++++
 tb/tb_rr_arbiter4.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with a registered one-hot grant, a mux select and
// an optional hold limit that forces a long-running owner to yield to waiting requesters.
module rr_arbiter4 #(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       preempt
);

  localparam int            CW       = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MAX);
  localparam bit            LIMITED  = (HOLD_MAX != 0);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_d;
  logic [3:0]    grant_q, grant_d;
  logic [1:0]    sel_q, sel_d;
  logic [1:0]    last_q, last_d;
  logic [CW-1:0] hold_q, hold_d;
  logic          preempt_q, preempt_d;

  logic          pick_valid;
  logic [1:0]    pick_idx;
  logic [1:0]    cand;
  logic          owner_req;
  logic          other_req;
  logic          at_limit;

  // Rotating priority: scan last+1 .. last+4 (mod 4); the previous owner is checked last.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = last_q;
    cand       = last_q;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign owner_req = req[sel_q];
  assign other_req = |(req & ~grant_q);
  assign at_limit  = LIMITED && (hold_q == HOLD_LIM);

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    if (reset) begin
      state     <= IDLE;
      grant_q   <= '0;
      sel_q     <= 2'd0;
      last_q    <= 2'd3;
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      state     <= state_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  // Next-state and next-register logic.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves a latch behind.
    state_d   = state;
    grant_d   = grant_q;
    sel_d     = sel_q;
    last_d    = last_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;

    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          grant_d = 4'b0001 << pick_idx;
          sel_d   = pick_idx;
          last_d  = pick_idx;
          hold_d  = CW'(1);
        end
      end
      GRANT: begin
        if (!owner_req) begin
          // A release wins over a coincident preemption, so no pulse here.
          state_d = IDLE;
          grant_d = '0;
        end else if (at_limit && other_req) begin
          state_d   = IDLE;
          grant_d   = '0;
          preempt_d = 1'b1;
        end else if (LIMITED && !at_limit) begin
          hold_d = hold_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Output logic.
  always_comb begin
    grant   = grant_q;
    sel     = sel_q;
    busy    = |grant_q;
    preempt = preempt_q;
  end

`ifndef SYNTHESIS
  a_onehot : assert property (@(posedge clk) $onehot0(grant_q));
  a_owner  : assert property (@(posedge clk) (grant_q != 4'b0) |-> grant_q[sel_q]);
  a_pulse  : assert property (@(posedge clk) disable iff (reset) preempt_q |=> !preempt_q);
  a_state  : assert property (@(posedge clk) (state == GRANT) == (grant_q != 4'b0));
`endif

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: three instances (hold limit 16, 4, unlimited) share one stimulus
// stream and are compared every cycle against an owner/priority model plus literal checks.
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;

  logic [3:0] grant   [3];
  logic [1:0] sel     [3];
  logic       busy    [3];
  logic       preempt [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic int hm_of(int g);
    return (g == 0) ? 16 : ((g == 1) ? 4 : 0);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    rr_arbiter4 #(.HOLD_MAX((g == 0) ? 16 : ((g == 1) ? 4 : 0))) u_dut (
      .clk    (clk),
      .reset  (reset),
      .req    (req),
      .grant  (grant[g]),
      .sel    (sel[g]),
      .busy   (busy[g]),
      .preempt(preempt[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: who owns the resource (-1 = nobody), who was last served, and for how long.
  int owner    [3];
  int last_own [3];
  int held     [3];
  int sel_m    [3];
  bit pre_m    [3];
  bit model_ok = 1'b0;

  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (reset) begin
        owner[g] = -1; last_own[g] = 3; held[g] = 0; sel_m[g] = 0; pre_m[g] = 1'b0;
      end else if (owner[g] < 0) begin
        pre_m[g] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
          int i;
          i = (last_own[g] + k) % 4;
          if (owner[g] < 0 && req[i]) begin
            owner[g] = i; last_own[g] = i; sel_m[g] = i; held[g] = 1;
          end
        end
      end else begin
        pre_m[g] = 1'b0;
        if (!req[owner[g]]) begin
          owner[g] = -1;
        end else if (hm_of(g) != 0 && held[g] >= hm_of(g) &&
                     (req & ~(4'b0001 << owner[g])) != 4'b0) begin
          owner[g] = -1;
          pre_m[g] = 1'b1;
        end else if (held[g] < 1000) begin
          held[g]++;
        end
      end
    end
    if (reset) model_ok = 1'b1;
  end

  // Every-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin
    if (model_ok) begin
      for (int g = 0; g < 3; g++) begin
        logic [3:0] eg;
        eg = (owner[g] < 0) ? 4'b0000 : (4'b0001 << owner[g]);
        check($sformatf("grant[%0d]", g), grant[g], eg);
        check($sformatf("sel[%0d]", g), sel[g], sel_m[g]);
        check($sformatf("busy[%0d]", g), busy[g], owner[g] >= 0);
        check($sformatf("preempt[%0d]", g), preempt[g], pre_m[g]);
        check($sformatf("onehot[%0d]", g), $onehot0(grant[g]), 1);
        check($sformatf("own_sel[%0d]", g), (grant[g] == 4'b0) || grant[g][sel[g]], 1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int order [4] = '{1, 3, 0, 1};
    reset = 1'b1;
    req   = 4'b0000;
    tick(2);
    for (int g = 0; g < 3; g++) begin
      check("rst_grant", grant[g], 4'b0000);
      check("rst_sel", sel[g], 2'd0);
      check("rst_busy", busy[g], 1'b0);
      check("rst_preempt", preempt[g], 1'b0);
    end

    // Single requester: one-edge latency, release drops the grant next edge.
    reset = 1'b0;
    req   = 4'b0100;
    tick(1);
    check("t1_grant", grant[0], 4'b0100);
    check("t1_sel", sel[0], 2'd2);
    check("t1_busy", busy[0], 1'b1);
    req = 4'b0000;
    tick(1);
    check("t1_release", grant[0], 4'b0000);

    // Bring last to 0, then rotate through 1,3,0,1 with one idle cycle between owners.
    req = 4'b0001;
    tick(1);
    check("t2_pre", grant[0], 4'b0001);
    req = 4'b0000;
    tick(1);
    req = 4'b1011;
    for (int s = 0; s < 4; s++) begin
      tick(1);
      check("t2_order", grant[0], 4'b0001 << order[s]);
      tick(1);
      check("t2_hold", grant[0], 4'b0001 << order[s]);
      req = 4'b1011 & ~(4'b0001 << order[s]);
      tick(1);
      check("t2_gap", grant[0], 4'b0000);
      req = 4'b1011;
    end
    req = 4'b0000;
    tick(2);

    // Hold limit 4 with a competitor: four cycles, preempt pulse, then requester 1.
    req = 4'b0011;
    for (int c = 0; c < 4; c++) begin
      tick(1);
      check("t3_hold", grant[1], 4'b0001);
      check("t3_nopre", preempt[1], 1'b0);
    end
    tick(1);
    check("t3_drop", grant[1], 4'b0000);
    check("t3_pulse", preempt[1], 1'b1);
    tick(1);
    check("t3_next", grant[1], 4'b0010);
    check("t3_sel", sel[1], 2'd1);
    check("t3_pulse_end", preempt[1], 1'b0);
    req = 4'b0000;
    tick(2);

    // Hold limit with nobody else waiting: never preempted.
    req = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      check("t4_grant", grant[1], 4'b0001);
      check("t4_nopre", preempt[1], 1'b0);
    end
    req = 4'b0000;
    tick(2);

    // Reset in the middle of a grant, then regrant one edge after release.
    req = 4'b1000;
    tick(1);
    check("t5_grant", grant[0], 4'b1000);
    reset = 1'b1;
    tick(1);
    check("t5_rst_grant", grant[0], 4'b0000);
    check("t5_rst_sel", sel[0], 2'd0);
    check("t5_rst_busy", busy[0], 1'b0);
    reset = 1'b0;
    tick(1);
    check("t5_regrant", grant[0], 4'b1000);
    check("t5_sel", sel[0], 2'd3);

    // Unlimited hold: requester 0 keeps the resource for 100 cycles.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    req   = 4'b1111;
    for (int c = 0; c < 100; c++) begin
      tick(1);
      check("t6_grant", grant[2], 4'b0001);
      check("t6_sel", sel[2], 2'd0);
    end
    req = 4'b0000;
    tick(2);

    // Randomized traffic with slowly changing requests and rare resets.
    for (int c = 0; c < 3000; c++) begin
      tick(1);
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) req = 4'($urandom());
    end
    reset = 1'b0;
    req   = 4'b0000;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
